sa_rx_sync: RTL and testbench
=============================

Name: sa_rx_sync

Overview:
- Clocked receiver terminating the self-timed Send/Ack four-phase handshake at the output of a copy/exclude stage.
- Synchronises Send_in into the CLK domain, captures the bundled data packet, and acknowledges it.
- Discards packets whose exclusion flag is low and buffers the rest in a small first-word-fall-through FIFO drained by a valid/ready consumer.
- Sits at the boundary between the self-timed DDP pipeline and clocked logic (host interface / trace capture).

Parameters:
- DW, 16, packet data width in bits.
- DEPTH, 4, FIFO depth in packets; power of two, ≥2.
- CW, 8, width of drop counter.

Ports:
- CLK  input  1  clock.
- MR  input  1  master reset, asynchronous, active-high.
- Send_in  input  1  request from self-timed sender; four-phase, level.
- Data_in  input  DW  bundled packet data; stable while Send_in high until Ack_out high.
- exb_in  input  1  bundled keep flag; 0 = exclude (consume and discard).
- Ack_out  output  1  acknowledge to sender.
- CP  output  1  one-cycle pulse per completed capture (kept or dropped).
- out_data  output  DW  FIFO head.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts head when out_valid & out_ready at a rising CLK edge.
- full  output  1  FIFO holds DEPTH packets.
- drop_cnt  output  CW  count of excluded packets.

Behaviour:
- Reset (MR high, asynchronous): synchroniser flops = 0, state = IDLE, Ack_out = 0, CP = 0, FIFO empty (out_valid = 0, full = 0, pointers = 0), out_data = 0, drop_cnt = 0. Reset may assert mid-handshake; the sender is reset by the same MR, so no handshake resumes after release.
- Synchroniser: two flops on Send_in, giving s_sync. Data_in and exb_in are sampled unsynchronised only at the capture edge; the bundling constraint guarantees they are stable ≥2 cycles before s_sync rises.
- FSM states:
  - IDLE: Ack_out = 0. Capture condition: s_sync = 1 and (exb_in = 0 or full = 0). On that edge:
    - exb_in = 1: push Data_in into the FIFO.
    - exb_in = 0: drop_cnt increments, wrapping modulo 2^CW.
    - Either way: CP = 1 for the next cycle, Ack_out = 1, go to ACK.
  - IDLE stall: s_sync = 1 with exb_in = 1 and full = 1 stays in IDLE with Ack_out low until a pop clears full.
  - ACK: Ack_out = 1. When s_sync = 0: Ack_out = 0, go to IDLE. A new capture needs a fresh s_sync rise seen in IDLE.
- Latency:
  - Send_in rise to Ack_out rise: 3 CLK edges when not stalled.
  - Send_in fall to Ack_out fall: 3 edges.
  - Minimum period: 6 cycles per packet.
  - Kept packet appears at out_valid/out_data on the cycle after the capture edge.
- Registered outputs: Ack_out, CP, full, out_valid and drop_cnt are all registered, with no combinational path from inputs.
- FIFO:
  - Pointers are log2(DEPTH)+1 bits; wrap-around is by MSB compare.
  - Pop and push on the same edge are both performed, with count unchanged.
  - full is evaluated on the registered state before the edge: when full, a pop and an IDLE capture cannot coincide; capture proceeds the next cycle.
  - out_data holds its last value when empty; out_valid governs it.
  - Pop when empty is ignored.

Test Plan:
- Single kept packet: Data_in = 16'hA5A5, exb_in = 1, raise Send_in → Ack_out high at 3rd edge, CP pulse 1 cycle, out_valid with out_data = A5A5 the next cycle. Drop Send_in → Ack_out low 3 edges later.
- Exclusion: 3 packets with exb_in = 0 → each fully acknowledged, out_valid stays 0, drop_cnt = 3, 3 CP pulses.
- Backpressure: out_ready = 0, send 5 kept packets (DEPTH = 4) → full = 1 after the 4th; the 5th holds Ack_out low. Assert out_ready one cycle → 1st packet popped and the 5th acknowledged. Drain order must be 1..5.
- Dropped packet while full: full = 1, exb_in = 0 → acknowledged without a pop, drop_cnt increments, FIFO contents unchanged.
- Drop counter wrap: 256 excluded packets with CW = 8 → drop_cnt returns to 0.
- Reset mid-handshake: assert MR while in ACK with 2 entries queued → Ack_out, out_valid, full and drop_cnt = 0 immediately, without waiting for a clock edge. After release, a new packet is captured normally.

Source files
------------

// File: rtl/sa_rx_sync_if.sv
// rtl/sa_rx_sync_if.sv - Send/Ack capture side and valid/ready drain side of sa_rx_sync
interface sa_rx_sync_if #(
    parameter int DW = 16,
    parameter int CW = 8
);
    logic          Send_in;
    logic [DW-1:0] Data_in;
    logic          exb_in;
    logic          Ack_out;
    logic          CP;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          full;
    logic [CW-1:0] drop_cnt;

    modport master (
        output Send_in, Data_in, exb_in, out_ready,
        input  Ack_out, CP, out_data, out_valid, full, drop_cnt
    );

    modport slave (
        input  Send_in, Data_in, exb_in, out_ready,
        output Ack_out, CP, out_data, out_valid, full, drop_cnt
    );
endinterface

// File: rtl/sa_rx_sync.sv
// rtl/sa_rx_sync.sv - four-phase Send/Ack receiver with exclusion drop and FWFT packet FIFO
module sa_rx_sync #(
    parameter int DW    = 16,
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input logic          CLK,
    input logic          MR,
    sa_rx_sync_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ACK  = 1'b1;

    logic          sync1;
    logic          s_sync;
    logic [0:0]    state;
    logic          cp_r;
    logic [CW-1:0] drops;
    logic [DW-1:0] head;
    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_next;
    logic [PW-1:0] rd_next;
    logic          empty_w;
    logic          full_w;
    logic          capture;
    logic          push;
    logic          pop;

    assign empty_w = (wr_ptr == rd_ptr);
    assign full_w  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A dropped packet never needs FIFO space, so only kept packets stall on full.
    assign capture = (state == IDLE) && s_sync && (!bus.exb_in || !full_w);
    assign push    = capture && bus.exb_in;
    assign pop     = !empty_w && bus.out_ready;
    assign wr_next = wr_ptr + PW'(push);
    assign rd_next = rd_ptr + PW'(pop);

    always_ff @(posedge CLK or posedge MR) begin
        if (MR) begin
            sync1  <= 1'b0;
            s_sync <= 1'b0;
            state  <= IDLE;
            cp_r   <= 1'b0;
            drops  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            head   <= '0;
        end else begin
            sync1  <= bus.Send_in;
            s_sync <= sync1;
            cp_r   <= capture;
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
            if (capture && !bus.exb_in) begin
                drops <= drops + CW'(1);
            end
            case (state)
                IDLE:    if (capture) state <= ACK;
                default: if (!s_sync) state <= IDLE;
            endcase
            // Head register tracks the next entry; bypass when it is the one being written now.
            if (wr_next != rd_next) begin
                head <= (push && (rd_next == wr_ptr)) ? bus.Data_in : mem[rd_next[AW-1:0]];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= bus.Data_in;
        end
    end

    assign bus.Ack_out   = (state == ACK);
    assign bus.CP        = cp_r;
    assign bus.out_data  = head;
    assign bus.out_valid = !empty_w;
    assign bus.full      = full_w;
    assign bus.drop_cnt  = drops;
endmodule

// File: tb/tb_sa_rx_sync.sv
// tb/tb_sa_rx_sync.sv - randomized self-checking bench for sa_rx_sync against a queue model
module tb_sa_rx_sync;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 8;

    logic clk = 1'b0;
    logic mr;
    int   errors = 0;
    int   checks = 0;
    bit   rnd_ready = 1'b0;

    logic [DW-1:0] exp_q[$];
    logic [CW-1:0] exp_drop = '0;

    sa_rx_sync_if #(.DW(DW), .CW(CW)) bus ();

    sa_rx_sync #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
        .CLK (clk),
        .MR  (mr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Advance one clock; a head accepted at this edge is checked against the model first.
    task automatic tick();
        if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got out_data=%h, required out_valid=0", bus.out_data);
            end else begin
                if (bus.out_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL pop_data: got %h, required %h", bus.out_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic handshake(input logic [DW-1:0] d, input logic e, output int rise,
                             output int fall, output int cps, output logic v_ack,
                             output logic [DW-1:0] d_ack);
        rise = -1; fall = -1; cps = 0; v_ack = 1'b0; d_ack = '0;
        bus.Data_in = d;
        bus.exb_in  = e;
        bus.Send_in = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (bus.CP) cps++;
            if (bus.Ack_out) begin
                rise = i;
                break;
            end
        end
        if (rise < 0) begin
            bus.Send_in = 1'b0;
            return;
        end
        v_ack = bus.out_valid;
        d_ack = bus.out_data;
        if (e) exp_q.push_back(d);
        else   exp_drop++;
        bus.Send_in = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (bus.CP) cps++;
            if (!bus.Ack_out) begin
                fall = i;
                break;
            end
        end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH; i++) begin
            if (!bus.out_valid) break;
            tick();
        end
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_empty: got out_valid=%b model_left=%0d, required 0 and 0",
                     bus.out_valid, exp_q.size());
        end
    endtask

    task automatic test_reset();
        mr = 1'b1;
        bus.Send_in = 1'b0; bus.Data_in = '0; bus.exb_in = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({bus.Ack_out, bus.CP, bus.out_valid, bus.full} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got ack/cp/valid/full=%b, required 0000",
                     {bus.Ack_out, bus.CP, bus.out_valid, bus.full});
        end
        checks++;
        if (bus.out_data !== '0 || bus.drop_cnt !== '0) begin
            errors++;
            $display("FAIL reset_data: got out_data=%h drop_cnt=%0d, required 0 and 0",
                     bus.out_data, bus.drop_cnt);
        end
        mr = 1'b0;
        tick(); tick();
        checks++;
        if (bus.Ack_out !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got ack=%b valid=%b, required 0 and 0", bus.Ack_out, bus.out_valid);
        end
    endtask

    task automatic test_single_kept();
        int rise, fall, cps;
        logic v;
        logic [DW-1:0] d;
        handshake(16'hA5A5, 1'b1, rise, fall, cps, v, d);
        checks++;
        if (rise != 3) begin errors++; $display("FAIL single_rise: got %0d edges, required 3", rise); end
        checks++;
        if (cps != 1) begin errors++; $display("FAIL single_cp: got %0d pulses, required 1", cps); end
        checks++;
        if (v !== 1'b1 || d !== 16'hA5A5) begin
            errors++;
            $display("FAIL single_head: got valid=%b data=%h, required 1 and a5a5", v, d);
        end
        checks++;
        if (fall != 3) begin errors++; $display("FAIL single_fall: got %0d edges, required 3", fall); end
        drain();
    endtask

    task automatic test_exclusion();
        int rise, fall, cps, total_cp = 0;
        logic v;
        logic [DW-1:0] d;
        for (int k = 0; k < 3; k++) begin
            handshake(DW'($urandom()), 1'b0, rise, fall, cps, v, d);
            total_cp += cps;
            checks++;
            if (rise != 3 || fall != 3 || v !== 1'b0) begin
                errors++;
                $display("FAIL excl_hs: got rise=%0d fall=%0d valid=%b, required 3 3 0", rise, fall, v);
            end
        end
        checks++;
        if (total_cp != 3) begin errors++; $display("FAIL excl_cp: got %0d, required 3", total_cp); end
        checks++;
        if (bus.drop_cnt !== exp_drop || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL excl_cnt: got drop_cnt=%0d valid=%b, required %0d and 0",
                     bus.drop_cnt, bus.out_valid, exp_drop);
        end
    endtask

    task automatic test_backpressure();
        int rise, fall, cps, wait_n;
        logic v;
        logic [DW-1:0] d, d5;
        rnd_ready = 1'b0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            handshake(DW'($urandom()), 1'b1, rise, fall, cps, v, d);
            checks++;
            if (rise != 3) begin errors++; $display("FAIL bp_fill_rise: got %0d, required 3", rise); end
        end
        checks++;
        if (bus.full !== 1'b1) begin errors++; $display("FAIL bp_full: got %b, required 1", bus.full); end
        handshake(DW'($urandom()), 1'b0, rise, fall, cps, v, d);
        checks++;
        if (rise != 3 || bus.full !== 1'b1 || bus.drop_cnt !== exp_drop || bus.out_data !== exp_q[0]) begin
            errors++;
            $display("FAIL bp_drop_full: got rise=%0d full=%b drop=%0d head=%h, required 3 1 %0d %h",
                     rise, bus.full, bus.drop_cnt, bus.out_data, exp_drop, exp_q[0]);
        end
        d5 = DW'($urandom());
        bus.Data_in = d5; bus.exb_in = 1'b1; bus.Send_in = 1'b1;
        repeat (8) tick();
        checks++;
        if (bus.Ack_out !== 1'b0) begin errors++; $display("FAIL bp_stall: got ack=%b, required 0", bus.Ack_out); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        wait_n = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (bus.Ack_out) begin wait_n = i; break; end
        end
        checks++;
        if (wait_n != 1) begin errors++; $display("FAIL bp_resume: got %0d edges after pop, required 1", wait_n); end
        exp_q.push_back(d5);
        bus.Send_in = 1'b0;
        for (int i = 0; i < 10 && bus.Ack_out; i++) tick();
        checks++;
        if (bus.Ack_out !== 1'b0) begin errors++; $display("FAIL bp_release: got ack=%b, required 0", bus.Ack_out); end
        drain();
    endtask

    task automatic test_reset_mid();
        int rise, fall, cps;
        logic v;
        logic [DW-1:0] d, dn;
        bus.out_ready = 1'b0;
        handshake(DW'($urandom()), 1'b0, rise, fall, cps, v, d);
        handshake(DW'($urandom()), 1'b1, rise, fall, cps, v, d);
        bus.Data_in = DW'($urandom()); bus.exb_in = 1'b1; bus.Send_in = 1'b1;
        for (int i = 0; i < 20 && !bus.Ack_out; i++) tick();
        #2;
        mr = 1'b1;
        bus.Send_in = 1'b0;
        #1;
        checks++;
        if ({bus.Ack_out, bus.CP, bus.out_valid, bus.full} !== 4'b0000 || bus.drop_cnt !== '0) begin
            errors++;
            $display("FAIL mid_reset: got ack/cp/valid/full=%b drop=%0d, required 0000 and 0",
                     {bus.Ack_out, bus.CP, bus.out_valid, bus.full}, bus.drop_cnt);
        end
        @(negedge clk);
        mr = 1'b0;
        exp_q.delete();
        exp_drop = '0;
        dn = DW'($urandom());
        handshake(dn, 1'b1, rise, fall, cps, v, d);
        checks++;
        if (rise != 3 || v !== 1'b1 || d !== dn) begin
            errors++;
            $display("FAIL mid_recover: got rise=%0d valid=%b data=%h, required 3 1 %h", rise, v, d, dn);
        end
        drain();
    endtask

    task automatic test_random();
        int rise, fall, cps;
        logic v;
        logic [DW-1:0] d;
        rnd_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            handshake(DW'($urandom()), 1'($urandom_range(0, 3) != 0), rise, fall, cps, v, d);
            checks++;
            if (rise < 3 || fall != 3 || cps != 1) begin
                errors++;
                $display("FAIL rand_hs%0d: got rise=%0d fall=%0d cp=%0d, required >=3 3 1", k, rise, fall, cps);
            end
        end
        rnd_ready = 1'b0;
        drain();
        checks++;
        if (bus.drop_cnt !== exp_drop) begin
            errors++;
            $display("FAIL rand_drop: got %0d, required %0d", bus.drop_cnt, exp_drop);
        end
    endtask

    task automatic test_wrap();
        int rise, fall, cps, total_cp = 0, bad = 0;
        logic v;
        logic [DW-1:0] d;
        mr = 1'b1;
        #1;
        mr = 1'b0;
        exp_q.delete();
        exp_drop = '0;
        for (int k = 0; k < 256; k++) begin
            handshake(DW'($urandom()), 1'b0, rise, fall, cps, v, d);
            total_cp += cps;
            if (rise != 3 || fall != 3) bad++;
            if (k == 254) begin
                checks++;
                if (bus.drop_cnt !== 8'd255) begin
                    errors++;
                    $display("FAIL wrap_255: got %0d, required 255", bus.drop_cnt);
                end
            end
        end
        checks++;
        if (bus.drop_cnt !== exp_drop || total_cp != 256 || bad != 0) begin
            errors++;
            $display("FAIL wrap_zero: got drop=%0d cp=%0d bad_hs=%0d, required %0d 256 0",
                     bus.drop_cnt, total_cp, bad, exp_drop);
        end
    endtask

    initial begin
        test_reset();
        test_single_kept();
        test_exclusion();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
